seven_seg_scanner: RTL and testbench

- Output stage directly downstream of processor_arm. Consumes a 32-bit value the processor writes and drives the two 4-digit multiplexed seven-segment displays on the D0_seg/D0_a and D1_seg/D1_a ports.
- D0 shows value bits [15:0]; D1 shows bits [31:16]. Both displays scan in lockstep, one digit at a time, at a divided refresh rate.

---
 rtl/seven_seg_scanner.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  seven_seg_scanner
//  Drives two multiplexed 4-digit seven-segment displays from a latched
//  32-bit value; optional leading-zero blanking under SEVEN_SEG_LZ_BLANK_EN.
//  Revision: 1.0
// ============================================================================
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        i_mclk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [7:0]  i_dp,
  input  logic        i_blank,
  output logic [7:0]  D0_seg,
  output logic [7:0]  D1_seg,
  output logic [3:0]  D0_a,
  output logic [3:0]  D1_a,
  output logic        o_frame
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [31:0]      r_disp;
  logic [7:0]       r_dp;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [7:0]       r_seg0;
  logic [7:0]       r_seg1;
  logic [3:0]       r_an;
  logic             r_frame;

  logic             w_tc;
  logic [3:0]       w_nib0;
  logic [3:0]       w_nib1;
  logic [6:0]       w_glyph0;
  logic [6:0]       w_glyph1;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_tc   = (r_cnt == c_CNT_MAX);
  assign w_nib0 = r_disp[{r_idx, 2'b00} +: 4];
  assign w_nib1 = r_disp[{1'b1, r_idx, 2'b00} +: 4];

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [3:0] w_lz0;
  logic [3:0] w_lz1;

  // Bit k set when nibble k and everything above it in that half is zero.
  always_comb begin
    w_lz0    = 4'b0000;
    w_lz1    = 4'b0000;
    w_lz0[1] = (r_disp[15:4]  == 12'h000);
    w_lz0[2] = (r_disp[15:8]  == 8'h00);
    w_lz0[3] = (r_disp[15:12] == 4'h0);
    w_lz1[1] = (r_disp[31:20] == 12'h000);
    w_lz1[2] = (r_disp[31:24] == 8'h00);
    w_lz1[3] = (r_disp[31:28] == 4'h0);
  end

  assign w_glyph0 = w_lz0[r_idx] ? 7'h7F : hex7(w_nib0);
  assign w_glyph1 = w_lz1[r_idx] ? 7'h7F : hex7(w_nib1);
`else
  assign w_glyph0 = hex7(w_nib0);
  assign w_glyph1 = hex7(w_nib1);
`endif

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_disp <= '0;
      r_dp   <= '0;
    end else if (i_wr_en) begin
      r_disp <= i_wr_data;
      r_dp   <= i_dp;
    end
  end

  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame pulse lands in the same cycle the index register reads 0 after 3.
  always_ff @(posedge i_mclk or posedge i_reset) begin
    if (i_reset) begin
      r_seg0  <= 8'hFF;
      r_seg1  <= 8'hFF;
      r_an    <= 4'hF;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_tc && (r_idx == 2'd3);
      if (i_blank) begin
        r_seg0 <= 8'hFF;
        r_seg1 <= 8'hFF;
        r_an   <= 4'hF;
      end else begin
        r_seg0 <= {~r_dp[{1'b0, r_idx}], w_glyph0};
        r_seg1 <= {~r_dp[{1'b1, r_idx}], w_glyph1};
        r_an   <= ~(4'b0001 << r_idx);
      end
    end
  end

  assign D0_seg  = r_seg0;
  assign D1_seg  = r_seg1;
  assign D0_a    = r_an;
  assign D1_a    = r_an;
  assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// Self-checking bench for seven_seg_scanner (REFRESH_DIV = 4) with a
// cycle-level scoreboard of expected output registers.
module tb_seven_seg_scanner;

  localparam int DIV = 4;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [7:0] c_LZ_HI = 8'hFF;
  localparam logic [7:0] c_LZ_D1 = 8'hFF;
`else
  localparam logic [7:0] c_LZ_HI = 8'hC0;
  localparam logic [7:0] c_LZ_D1 = 8'hC0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        wr    = 1'b0;
  logic        blank = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  wdp   = '0;
  logic [7:0]  d0s, d1s;
  logic [3:0]  d0a, d1a;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic       fr;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_disp = '0;
  logic [7:0]  m_dp   = '0;
  int          m_cnt  = 0;
  int          m_idx  = 0;

  logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] ANODE [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .CNT_W(16)) dut (
    .i_mclk   (clk),
    .i_reset  (rst),
    .i_wr_en  (wr),
    .i_wr_data(wdata),
    .i_dp     (wdp),
    .i_blank  (blank),
    .D0_seg   (d0s),
    .D1_seg   (d1s),
    .D0_a     (d0a),
    .D1_a     (d1a),
    .o_frame  (frame)
  );

  function automatic logic [6:0] glyph(input logic [15:0] half, input int k);
    logic [15:0] sh;
    sh = half >> (4 * k);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (k != 0 && sh == 16'h0000) return 7'h7F;
`endif
    return GLYPH[sh[3:0]];
  endfunction

  // One clock: predict the output registers from pre-edge model state, push
  // the prediction, advance the model, and settle 1 time unit past the edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      e = {8'hFF, 8'hFF, 4'hF, 4'hF, 1'b0};
      m_disp = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
    end else begin
      e.fr = (m_cnt == DIV - 1) && (m_idx == 3);
      if (blank) begin
        e.s0 = 8'hFF; e.s1 = 8'hFF; e.a0 = 4'hF; e.a1 = 4'hF;
      end else begin
        e.a0 = ANODE[m_idx];
        e.a1 = ANODE[m_idx];
        e.s0 = {~m_dp[m_idx],     glyph(m_disp[15:0],  m_idx)};
        e.s1 = {~m_dp[m_idx + 4], glyph(m_disp[31:16], m_idx)};
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
      if (wr) begin
        m_disp = wdata;
        m_dp   = wdp;
      end
    end
    q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
    rst = 1'b0;
    cycle();
    e = q.pop_front(); n_cmp++;
    if ({d0s, d1s, d0a, d1a, frame} !== e) begin
      n_bad++;
      $display("FAIL reset_release: got %h %h %h %h %b expected %h %h %h %h %b",
               d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
    end
    n_cmp++;
    if ({d0a, d1a, d0s, d1s} !== {4'hE, 4'hE, 8'hC0, 8'hC0}) begin
      n_bad++;
      $display("FAIL reset_first_edge: got a=%h/%h seg=%h/%h expected E/E C0/C0",
               d0a, d1a, d0s, d1s);
    end
  endtask

  task automatic test_write();
    exp_t e;
    wr = 1'b1; wdata = 32'h89AB_0123; wdp = 8'h00;
    for (int i = 0; i < 18; i++) begin
      cycle();
      wr = 1'b0;
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL write[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
      if (i == 1) begin
        n_cmp++;
        if ({d0a, d0s, d1s} !== {4'hE, 8'hB0, 8'h83}) begin
          n_bad++;
          $display("FAIL write_latency: got a=%h seg=%h/%h expected E B0/83", d0a, d0s, d1s);
        end
      end
    end
  endtask

  task automatic test_frame();
    exp_t e;
    int frames = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL frame[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
      if (frame === 1'b1) frames++;
    end
    n_cmp++;
    if (frames != 3) begin
      n_bad++;
      $display("FAIL frame_count: got %0d pulses in 48 cycles, expected 3", frames);
    end
  endtask

  task automatic test_blank();
    exp_t e;
    blank = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) blank = 1'b0;
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL blank[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      wr    = (i < 3);
      wdata = (i < 3) ? $urandom : wdata;
      wdp   = (i < 3) ? 8'($urandom) : wdp;
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      wr    = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
      wdp   = 8'($urandom);
      blank = ($urandom_range(0, 9) == 0);
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
    wr = 1'b0; blank = 1'b0;
  endtask

  task automatic test_lz_blank();
    exp_t e;
    wr = 1'b1; wdata = 32'h0000_0050; wdp = 8'h01;
    for (int i = 0; i < 20; i++) begin
      cycle();
      wr = 1'b0;
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL lz[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
      if (i >= 2) begin
        n_cmp++;
        if ((e.a0 == 4'hE && {d0s, d1s} !== {8'h40, 8'hC0}) ||
            (e.a0 == 4'hD && {d0s, d1s} !== {8'h92, c_LZ_D1}) ||
            ((e.a0 == 4'hB || e.a0 == 4'h7) && {d0s, d1s} !== {c_LZ_HI, c_LZ_D1})) begin
          n_bad++;
          $display("FAIL lz_glyph[%0d]: anode %h got %h/%h", i, e.a0, d0s, d1s);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    wr = 1'b1; wdata = 32'hFFFF_FFFF; wdp = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      wr = 1'b0;
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL async_pre[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
    #2;
    rst = 1'b1;
    m_disp = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
    #1;
    n_cmp++;
    if ({d0s, d1s, d0a, d1a, frame} !== {8'hFF, 8'hFF, 4'hF, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h %h %h %h %b expected FF FF F F 0",
               d0s, d1s, d0a, d1a, frame);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b0;
      cycle();
      e = q.pop_front(); n_cmp++;
      if ({d0s, d1s, d0a, d1a, frame} !== e) begin
        n_bad++;
        $display("FAIL async_post[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                 i, d0s, d1s, d0a, d1a, frame, e.s0, e.s1, e.a0, e.a1, e.fr);
      end
    end
    n_cmp++;
    if ({d0s, d1s} !== {8'hC0, 8'hC0}) begin
      n_bad++;
      $display("FAIL async_cleared: got seg %h/%h expected C0/C0", d0s, d1s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_frame();
    test_blank();
    test_back_to_back();
    test_lz_blank();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
